fetch_stage: RTL and testbench

//  RV32 instruction-fetch stage. Owns the architectural PC and issues word requests to instruction memory.

---
 rtl/rv32_core_pkg.sv | 15 +
 rtl/fetch_stage_if.sv | 26 ++
 rtl/fetch_fifo.sv | 49 ++++
 rtl/fetch_stage.sv | 77 +++++++
 tb/tb_fetch_stage.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rv32_core_pkg.sv
// rv32_core_pkg: shared RV32 widths, fetch entry type and PC helpers
package rv32_core_pkg;
  localparam int XLEN = 32;
  localparam int ILEN = 32;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] a);
    return {a[XLEN-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: imem request/response, decode handoff and branch redirect signals
interface fetch_stage_if;
  import rv32_core_pkg::*;
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] addr;
  logic            resp_valid;
  logic [ILEN-1:0] resp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;
  logic            take;
  logic [XLEN-1:0] next_pc;
  logic            misalign;

  modport master (
    output req_valid, addr, inst_valid, inst, inst_pc, misalign,
    input  req_ready, resp_valid, resp_data, inst_ready, take, next_pc
  );

  modport slave (
    input  req_valid, addr, inst_valid, inst, inst_pc, misalign,
    output req_ready, resp_valid, resp_data, inst_ready, take, next_pc
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with flush and occupancy count; DEPTH must be a power of 2
module fetch_fifo
  import rv32_core_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  T                           din,
  output T                           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  T mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;

  // a full queue still accepts a push when the head leaves in the same cycle
  assign do_pop  = pop && count != '0;
  assign do_push = push && (count != FULL || do_pop);
  assign head    = mem[rd_ptr];

  // storage, pointers and count; flush empties the queue and wins over push/pop
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: RV32 fetch stage owning the PC, issuing imem requests and buffering tagged instructions
module fetch_stage
  import rv32_core_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
  parameter int              FIFO_DEPTH      = 2,
  parameter int              MAX_OUTSTANDING = 2
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);
  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  logic [XLEN-1:0] pc, pend_pc;
  logic [OCW-1:0]  outstanding, drop_cnt;
  logic [FCW-1:0]  fifo_count;
  logic            misalign, accept, resp, drop, credit;
  fetch_entry_t    head, fill;

  // requests only go out when every in-flight response is guaranteed a FIFO slot
  assign credit = int'(outstanding) < MAX_OUTSTANDING &&
                  int'(outstanding) + int'(fifo_count) < FIFO_DEPTH;
  assign bus.req_valid  = rst_n && !bus.take && credit;
  assign bus.addr       = pc;
  assign accept         = bus.req_valid && bus.req_ready;
  assign resp           = bus.resp_valid;
  assign drop           = resp && drop_cnt != '0;
  assign fill           = '{pc: pend_pc, inst: bus.resp_data};
  assign bus.inst_valid = fifo_count != '0;
  assign bus.inst       = head.inst;
  assign bus.inst_pc    = head.pc;
  assign bus.misalign   = misalign;

  // address of every accepted request, popped in order as responses return
  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(MAX_OUTSTANDING)) pend_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (resp),
    .flush (1'b0),
    .din   (pc),
    .head  (pend_pc),
    .count (outstanding)
  );

  // instruction buffer toward decode; a redirect flushes it
  fetch_fifo #(.DEPTH(FIFO_DEPTH)) inst_q (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (resp && !drop),
    .pop   (bus.inst_ready),
    .flush (bus.take),
    .din   (fill),
    .head  (head),
    .count (fifo_count)
  );

  // PC, stale-response counter and misalign pulse; a redirect overrides everything,
  // and every request still in flight after the redirect cycle becomes stale
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc       <= RESET_PC;
      drop_cnt <= '0;
      misalign <= 1'b0;
    end else begin
      misalign <= bus.take && |bus.next_pc[1:0];
      if (bus.take) begin
        pc       <= align_pc(bus.next_pc);
        drop_cnt <= outstanding - OCW'(resp);
      end else begin
        if (accept) pc <= pc + PC_STEP;
        if (drop) drop_cnt <= drop_cnt - 1'b1;
      end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios with a scoreboard checking every delivered instruction
module tb_fetch_stage;
  import rv32_core_pkg::*;

  localparam logic [31:0] KEY = 32'h1357_9BDF;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  fetch_stage_if bus();

  fetch_stage #(.RESET_PC(32'h1000), .FIFO_DEPTH(2), .MAX_OUTSTANDING(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int           n_vec = 0;
  int           n_err = 0;
  int           budget = 0;
  logic         hold = 1'b0;
  fetch_entry_t exp_q[$];
  logic [31:0]  mq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [31:0] pc);
    exp_q.push_back('{pc: pc, inst: pc ^ KEY});
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 100) begin
      @(negedge clk);
      c++;
    end
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL %s drain: %0d entries never delivered, want 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    bus.take = 1'b0;
    bus.next_pc = '0;
    bus.inst_ready = 1'b0;
    hold = 1'b0;
    budget = 0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  // imem model: accepts up to 'budget' requests, answers in order after one cycle unless held
  initial begin
    bus.req_ready = 1'b0;
    bus.resp_valid = 1'b0;
    bus.resp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        mq.delete();
        bus.resp_valid = 1'b0;
      end else if (!hold && mq.size() != 0) begin
        bus.resp_valid = 1'b1;
        bus.resp_data = mq.pop_front() ^ KEY;
      end else bus.resp_valid = 1'b0;
      bus.req_ready = budget > 0;
      #3;
      if (rst_n && bus.req_valid && bus.req_ready) begin
        mq.push_back(bus.addr);
        budget--;
      end
    end
  end

  // scoreboard monitor: every decode handshake must match the oldest expected entry
  initial begin : monitor
    fetch_entry_t e;
    forever begin
      @(negedge clk);
      #3;
      if (rst_n && !bus.take && bus.inst_valid && bus.inst_ready) begin
        n_vec++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected inst: got pc %h inst %h, want none", bus.inst_pc, bus.inst);
        end else begin
          e = exp_q.pop_front();
          if ({bus.inst_pc, bus.inst} !== e) begin
            n_err++;
            $display("FAIL inst: got pc %h inst %h, want pc %h inst %h", bus.inst_pc, bus.inst, e.pc, e.inst);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.take = 1'b0;
    bus.next_pc = '0;
    bus.inst_ready = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_valid", 32'(bus.req_valid), 32'd0);
    chk("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("rst_inst", bus.inst, 32'd0);
    chk("rst_inst_pc", bus.inst_pc, 32'd0);
    chk("rst_misalign", 32'(bus.misalign), 32'd0);
    chk("rst_addr", bus.addr, 32'h1000);
    cyc(1);
    rst_n = 1'b1;
    #2;
    chk("post_rst_req_valid", 32'(bus.req_valid), 32'd1);
    chk("post_rst_addr", bus.addr, 32'h1000);

    // T1: streaming fetch from RESET_PC
    cyc(1);
    bus.inst_ready = 1'b1;
    expect_pc(32'h1000);
    expect_pc(32'h1004);
    expect_pc(32'h1008);
    budget = 3;
    drain("t1");
    cyc(3);
    #2 chk("t1_addr", bus.addr, 32'h100c);

    // T2: decode stalled, buffer fills and requests stop
    do_reset();
    expect_pc(32'h1000);
    expect_pc(32'h1004);
    expect_pc(32'h1008);
    budget = 3;
    cyc(6);
    #2;
    chk("t2_req_blocked", 32'(bus.req_valid), 32'd0);
    chk("t2_inst_valid", 32'(bus.inst_valid), 32'd1);
    chk("t2_head_pc", bus.inst_pc, 32'h1000);
    cyc(1);
    bus.inst_ready = 1'b1;
    drain("t2");

    // T3: redirect with two requests in flight, one answered in the redirect cycle
    do_reset();
    bus.inst_ready = 1'b1;
    hold = 1'b1;
    budget = 2;
    cyc(4);
    #2 chk("t3_outstanding_full", 32'(bus.req_valid), 32'd0);
    cyc(1);
    bus.take = 1'b1;
    bus.next_pc = 32'h2000;
    hold = 1'b0;
    cyc(1);
    bus.take = 1'b0;
    expect_pc(32'h2000);
    expect_pc(32'h2004);
    budget = 2;
    drain("t3");

    // T4: back-to-back redirects, the later target wins
    do_reset();
    bus.inst_ready = 1'b1;
    hold = 1'b1;
    budget = 2;
    cyc(4);
    bus.take = 1'b1;
    bus.next_pc = 32'h2000;
    cyc(1);
    bus.next_pc = 32'h3000;
    hold = 1'b0;
    cyc(1);
    bus.take = 1'b0;
    expect_pc(32'h3000);
    expect_pc(32'h3004);
    budget = 2;
    #2 chk("t4_addr", bus.addr, 32'h3000);
    drain("t4");

    // T5: misaligned redirect target
    do_reset();
    bus.inst_ready = 1'b1;
    bus.take = 1'b1;
    bus.next_pc = 32'h2002;
    #2;
    chk("t5_no_req_on_take", 32'(bus.req_valid), 32'd0);
    chk("t5_misalign_before", 32'(bus.misalign), 32'd0);
    cyc(1);
    bus.take = 1'b0;
    expect_pc(32'h2000);
    budget = 1;
    #2;
    chk("t5_misalign_pulse", 32'(bus.misalign), 32'd1);
    chk("t5_addr", bus.addr, 32'h2000);
    cyc(1);
    #2 chk("t5_misalign_end", 32'(bus.misalign), 32'd0);
    drain("t5");

    // T6: reset asserted mid-stream
    do_reset();
    budget = 10;
    cyc(5);
    #2;
    chk("t6_buffered", 32'(bus.inst_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_inst_valid", 32'(bus.inst_valid), 32'd0);
    chk("t6_inst", bus.inst, 32'd0);
    chk("t6_inst_pc", bus.inst_pc, 32'd0);
    chk("t6_req_valid", 32'(bus.req_valid), 32'd0);
    budget = 0;
    cyc(2);
    rst_n = 1'b1;
    #2 chk("t6_addr", bus.addr, 32'h1000);
    cyc(1);
    expect_pc(32'h1000);
    budget = 1;
    bus.inst_ready = 1'b1;
    drain("t6");

    // T7: PC wraps past the top of the address space
    do_reset();
    bus.inst_ready = 1'b1;
    bus.take = 1'b1;
    bus.next_pc = 32'hFFFF_FFFC;
    cyc(1);
    bus.take = 1'b0;
    expect_pc(32'hFFFF_FFFC);
    expect_pc(32'h0000_0000);
    budget = 2;
    drain("t7");
    cyc(2);
    #2 chk("t7_addr", bus.addr, 32'h0000_0004);

    cyc(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
